// File: rtl/uart_host_tx.sv
// ---------------------------------------------------------------------------
// uart_host_tx
//
// Host-side UART frame generator. Bytes from a host are buffered in a small
// FIFO. Each byte goes out as one frame: a start bit, the data bits LSB
// first, an optional parity bit and a stop bit. TX_OUT idles high.
//
// The parity encoding matches the system UART config register:
//   PAR_EN  = 1 appends a parity bit.
//   PAR_TYP = 0 selects even parity, 1 selects odd parity.
//
// Ports
//   CLK       single clock for all logic
//   RST       synchronous, active-high reset
//   PAR_EN    append a parity bit (sampled when a byte is popped)
//   PAR_TYP   0 = even parity, 1 = odd parity (sampled at pop)
//   BIT_DIV   CLK cycles per serial bit; 0 behaves as 1 (sampled at pop)
//   IN_DATA   byte to transmit
//   IN_VLD    IN_DATA valid; the byte is written when IN_VLD & IN_RDY
//   IN_RDY    the FIFO can accept a byte
//   TX_OUT    registered serial line; connects to UART_RX_IN
//   BUSY      a frame is in progress or bytes are still buffered
//   FIFO_CNT  bytes buffered, not counting the byte being shifted out
// ---------------------------------------------------------------------------
module uart_host_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [7:0]            BIT_DIV,
  input  logic [DATA_WIDTH-1:0] IN_DATA,
  input  logic                  IN_VLD,
  output logic                  IN_RDY,
  output logic                  TX_OUT,
  output logic                  BUSY,
  output logic [CNT_W-1:0]      FIFO_CNT
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                state, state_next;

  // FIFO storage and bookkeeping
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      cnt;

  // Frame datapath
  logic [DATA_WIDTH-1:0] shift;
  logic [7:0]            div_q;       // latched cycles per bit, never 0
  logic [7:0]            div_cnt;     // 0 .. div_q-1
  logic [BIT_W-1:0]      bit_cnt;     // data bit index
  logic                  par_en_q;
  logic                  par_bit_q;   // parity bit value, computed at pop
  logic                  tx_q, tx_next;

  logic                  push, pop;
  logic                  div_last;
  logic [DATA_WIDTH-1:0] head;

  // Ready depends only on the occupancy register (and reset); a pop in
  // the same cycle does not make room early.
  assign IN_RDY   = ~RST & (cnt < CNT_W'(FIFO_DEPTH));
  assign push     = IN_VLD & IN_RDY;
  assign head     = mem[rd_ptr];
  assign div_last = (div_cnt == div_q - 8'd1);

  assign TX_OUT   = tx_q;
  assign FIFO_CNT = cnt;
  assign BUSY     = (state != IDLE) | (cnt != '0);

  // Next-state and next-line-value logic. tx_next is the level the line
  // takes on the coming edge, so TX_OUT stays a plain flop.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // through the case statement leaves a value unassigned (no latches).
    state_next = state;
    tx_next    = tx_q;
    pop        = 1'b0;

    unique case (state)
      IDLE: begin
        tx_next = 1'b1;
        if (cnt != '0) begin
          pop        = 1'b1;
          state_next = START;
          tx_next    = 1'b0;
        end
      end

      START: begin
        if (div_last) begin
          state_next = DATA;
          tx_next    = shift[0];
        end
      end

      DATA: begin
        if (div_last) begin
          if (bit_cnt == BIT_W'(DATA_WIDTH - 1)) begin
            if (par_en_q) begin
              state_next = PARITY;
              tx_next    = par_bit_q;
            end else begin
              state_next = STOP;
              tx_next    = 1'b1;
            end
          end else begin
            // The shift register moves on this same edge.
            tx_next = shift[1];
          end
        end
      end

      PARITY: begin
        if (div_last) begin
          state_next = STOP;
          tx_next    = 1'b1;
        end
      end

      STOP: begin
        if (div_last) begin
          if (cnt != '0) begin
            // Back-to-back frame: no idle bit between stop and start.
            pop        = 1'b1;
            state_next = START;
            tx_next    = 1'b0;
          end else begin
            state_next = IDLE;
            tx_next    = 1'b1;
          end
        end
      end

      default: begin
        state_next = IDLE;
        tx_next    = 1'b1;
      end
    endcase
  end

  // NOTE: the FIFO array has no reset; emptiness is tracked by the pointers
  // and count, so stale contents are never observed and the array can map
  // onto plain storage without reset wiring.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= IN_DATA;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples values from before the edge, independent of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      tx_q      <= 1'b1;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      shift     <= '0;
      div_q     <= 8'd1;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else begin
      state <= state_next;
      tx_q  <= tx_next;

      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);

      unique case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase

      if (pop) begin
        // Frame settings are frozen here for the whole frame.
        shift     <= head;
        div_q     <= (BIT_DIV == 8'd0) ? 8'd1 : BIT_DIV;
        par_en_q  <= PAR_EN;
        par_bit_q <= (^head) ^ PAR_TYP;
        div_cnt   <= '0;
        bit_cnt   <= '0;
      end else if (state != IDLE) begin
        div_cnt <= div_last ? 8'd0 : div_cnt + 8'd1;
        if (state == DATA && div_last) begin
          shift   <= shift >> 1;
          bit_cnt <= bit_cnt + BIT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_host_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_host_tx
//
// Self-checking bench for uart_host_tx. Accepted bytes are queued as
// expected frames; a monitor decodes TX_OUT cycle by cycle and compares
// each frame against a waveform built from the byte and the configuration
// that was present on the pop edge.
// ---------------------------------------------------------------------------
module tb_uart_host_tx;

  logic       CLK;
  logic       RST;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [7:0] BIT_DIV;
  logic [7:0] IN_DATA;
  logic       IN_VLD;
  logic       IN_RDY;
  logic       TX_OUT;
  logic       BUSY;
  logic [2:0] FIFO_CNT;

  uart_host_tx #(
    .DATA_WIDTH (8),
    .FIFO_DEPTH (4),
    .CNT_W      (3)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .PAR_EN   (PAR_EN),
    .PAR_TYP  (PAR_TYP),
    .BIT_DIV  (BIT_DIV),
    .IN_DATA  (IN_DATA),
    .IN_VLD   (IN_VLD),
    .IN_RDY   (IN_RDY),
    .TX_OUT   (TX_OUT),
    .BUSY     (BUSY),
    .FIFO_CNT (FIFO_CNT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  logic [7:0] sb[$];          // expected bytes, in order
  int         frame_start[$]; // cycle of each observed start bit
  int         last_start = 0;
  logic       in_frame   = 1'b0;

  // Configuration as seen by the DUT on the most recent edge.
  logic [7:0] snap_div;
  logic       snap_pe;
  logic       snap_pt;

  always @(posedge CLK) begin
    cyc      <= cyc + 1;
    snap_div <= BIT_DIV;
    snap_pe  <= PAR_EN;
    snap_pt  <= PAR_TYP;
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // -------------------------------------------------------------------------
  // Monitor: decode each frame and compare with the reference waveform.
  // -------------------------------------------------------------------------
  initial begin : monitor
    logic [7:0] exp_b;
    logic [7:0] act_b;
    logic       bits [11];
    int         nbits;
    int         d;
    int         first_bad;
    bit         aborted;
    forever begin
      @(negedge CLK);
      if (RST !== 1'b0) continue;
      if (TX_OUT === 1'b0) begin
        in_frame   = 1'b1;
        last_start = cyc;
        frame_start.push_back(cyc);
        d     = (snap_div == 8'd0) ? 1 : int'(snap_div);
        nbits = snap_pe ? 11 : 10;
        check("frame_expected", 32'(sb.size() != 0), 32'd1);
        exp_b = (sb.size() != 0) ? sb.pop_front() : 8'h00;
        // Reference frame: start, data LSB first, parity, stop.
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = exp_b[i];
        if (snap_pe) begin
          // Even parity: total ones even; odd parity: total ones odd.
          bits[9]  = ($countones(exp_b) % 2 == 1) ^ snap_pt;
          bits[10] = 1'b1;
        end else begin
          bits[9]  = 1'b1;
          bits[10] = 1'b1;
        end
        first_bad = -1;
        act_b     = 8'h00;
        aborted   = 1'b0;
        for (int c = 0; c < nbits * d; c++) begin
          if (c > 0) begin
            @(negedge CLK);
            if (RST !== 1'b0) begin
              aborted = 1'b1;
              break;
            end
          end
          if (TX_OUT !== bits[c / d] && first_bad < 0) first_bad = c;
          if ((c % d) == 0 && (c / d) >= 1 && (c / d) <= 8)
            act_b[(c / d) - 1] = TX_OUT;
        end
        if (!aborted) begin
          check("frame_first_bad_cycle", 32'(first_bad), 32'hFFFF_FFFF);
          check("frame_data", 32'(act_b), 32'(exp_b));
        end
        in_frame = 1'b0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus helpers. All driving happens 1 time unit after a rising edge.
  // -------------------------------------------------------------------------
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Present a byte until accepted; returns the accept edge and whether
  // IN_RDY was high on the first cycle it was offered.
  task automatic push_byte(input logic [7:0] b, output int acc,
                           output bit first_rdy);
    bit done;
    done      = 1'b0;
    first_rdy = 1'b0;
    acc       = -1;
    IN_DATA   = b;
    IN_VLD    = 1'b1;
    for (int n = 0; n < 500; n++) begin
      @(negedge CLK);
      if (n == 0) first_rdy = (IN_RDY === 1'b1);
      if (IN_RDY === 1'b1) begin
        acc = cyc + 1;
        sb.push_back(b);
        done = 1'b1;
        step();
        break;
      end
      step();
    end
    IN_VLD = 1'b0;
    if (!done) check("push_timeout", 32'd0, 32'd1);
  endtask

  // Wait for BUSY to fall; returns the cycle of the first low sample.
  task automatic wait_idle(output int drop);
    bit done;
    done = 1'b0;
    drop = -1;
    for (int n = 0; n < 3000; n++) begin
      @(negedge CLK);
      if (BUSY === 1'b0 && !in_frame) begin
        drop = cyc;
        done = 1'b1;
        break;
      end
    end
    if (!done) check("idle_timeout", 32'd0, 32'd1);
    step();
  endtask

  // -------------------------------------------------------------------------
  // Test sequence
  // -------------------------------------------------------------------------
  int acc, acc6, drop, n0, nfr;
  bit rdy, rdy6;

  initial begin
    RST     = 1'b1;
    PAR_EN  = 1'b0;
    PAR_TYP = 1'b0;
    BIT_DIV = 8'd4;
    IN_DATA = 8'h00;
    IN_VLD  = 1'b0;

    // Reset
    repeat (3) step();
    @(negedge CLK);
    check("rdy_low_in_reset", 32'(IN_RDY), 32'd0);
    step();
    RST = 1'b0;
    @(negedge CLK);
    check("reset_tx", 32'(TX_OUT), 32'd1);
    check("reset_cnt", 32'(FIFO_CNT), 32'd0);
    check("reset_busy", 32'(BUSY), 32'd0);
    check("rdy_after_reset", 32'(IN_RDY), 32'd1);
    step();

    // Single frame 0xA5, DIV=4, no parity
    push_byte(8'hA5, acc, rdy);
    wait_idle(drop);
    check("latency_0xA5", 32'(last_start), 32'(acc + 1));
    check("busy_len_0xA5", 32'(drop - last_start), 32'd40);
    check("cnt_after_0xA5", 32'(FIFO_CNT), 32'd0);
    check("tx_idle_0xA5", 32'(TX_OUT), 32'd1);

    // Parity: even then odd, DIV=2
    PAR_EN = 1'b1; PAR_TYP = 1'b0; BIT_DIV = 8'd2;
    push_byte(8'h07, acc, rdy);
    wait_idle(drop);
    check("busy_len_even", 32'(drop - last_start), 32'd22);
    PAR_TYP = 1'b1;
    push_byte(8'h07, acc, rdy);
    wait_idle(drop);
    check("busy_len_odd", 32'(drop - last_start), 32'd22);

    // Burst of 6 with IN_VLD held, DIV=3
    PAR_EN = 1'b0; PAR_TYP = 1'b0; BIT_DIV = 8'd3;
    n0 = frame_start.size();
    for (int i = 0; i < 5; i++) begin
      push_byte(8'h10 + 8'(i), acc, rdy);
      check("burst_rdy", 32'(rdy), 32'd1);
    end
    check("burst_cnt_full", 32'(FIFO_CNT), 32'd4);
    push_byte(8'h15, acc6, rdy6);
    check("burst_6th_blocked", 32'(rdy6), 32'd0);
    wait_idle(drop);
    check("burst_frames", 32'(frame_start.size() - n0), 32'd6);
    if (frame_start.size() - n0 == 6) begin
      check("burst_6th_accept", 32'(acc6), 32'(frame_start[n0] + 31));
      for (int i = 1; i < 6; i++)
        check("burst_contiguous",
              32'(frame_start[n0+i] - frame_start[n0+i-1]), 32'd30);
    end

    // BIT_DIV=0 behaves as 1
    BIT_DIV = 8'd0;
    push_byte(8'h3C, acc, rdy);
    wait_idle(drop);
    check("busy_len_div0", 32'(drop - last_start), 32'd10);

    // Reset in the middle of a 0xFF frame with two bytes buffered
    BIT_DIV = 8'd2;
    push_byte(8'hFF, acc, rdy);
    push_byte(8'h01, acc, rdy);
    push_byte(8'h02, acc, rdy);
    for (int n = 0; n < 200 && cyc < last_start + 8; n++) step();
    check("pre_reset_cnt", 32'(FIFO_CNT), 32'd2);
    RST = 1'b1;
    @(negedge CLK);
    check("rdy_low_mid_reset", 32'(IN_RDY), 32'd0);
    step();
    RST = 1'b0;
    sb.delete();
    @(negedge CLK);
    check("abort_tx", 32'(TX_OUT), 32'd1);
    check("abort_cnt", 32'(FIFO_CNT), 32'd0);
    check("abort_busy", 32'(BUSY), 32'd0);
    nfr = frame_start.size();
    repeat (60) step();
    check("abort_no_frames", 32'(frame_start.size()), 32'(nfr));

    // Mid-frame configuration change
    PAR_EN = 1'b0; PAR_TYP = 1'b0; BIT_DIV = 8'd2;
    n0 = frame_start.size();
    push_byte(8'h5A, acc, rdy);
    push_byte(8'hC3, acc, rdy);
    repeat (5) step();
    PAR_EN = 1'b1; PAR_TYP = 1'b1; BIT_DIV = 8'd1;
    wait_idle(drop);
    check("cfg_frames", 32'(frame_start.size() - n0), 32'd2);
    if (frame_start.size() - n0 == 2)
      check("cfg_old_len", 32'(frame_start[n0+1] - frame_start[n0]), 32'd20);
    check("cfg_new_len", 32'(drop - last_start), 32'd11);

    // Randomized traffic with configuration changes at random times
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        BIT_DIV = 8'($urandom_range(0, 3));
        PAR_EN  = 1'($urandom_range(0, 1));
        PAR_TYP = 1'($urandom_range(0, 1));
      end
      push_byte(8'($urandom_range(0, 255)), acc, rdy);
      repeat ($urandom_range(0, 12)) step();
    end
    wait_idle(drop);
    check("random_drained", 32'(sb.size()), 32'd0);
    check("random_cnt", 32'(FIFO_CNT), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
